csr_spi_bridge: RTL and testbench
=================================

# csr_spi_bridge

Parametrised bridge between the byte stream of the SPI transceiver (`spi_trx`) and a generic CSR bus. It replaces the fixed 12-bit-address, 8-bit-data SPI CSR front end. The bridge adds configurable address width, multi-byte register words, configurable read latency and a fixed-address (non-incrementing) burst mode. It sits between `spi_trx` and the register file in the CSR subsystem.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: CSR address width, 1..16. `ADDR_BYTES` = ceil(ADDR_WIDTH/8) is derived.
- `DATA_BYTES`, 1: bytes per CSR word, 1..4. `DATA_WIDTH` = 8*DATA_BYTES is derived.
- `RD_LATENCY`, 1: cycles from `csr_re_o` to valid `csr_rdata_i`, 0..3.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-low reset.
- `spi_rst_i`  in  1  transceiver session reset (ss deasserted), active-high, synchronous to `clk`.
- `rx_data_i`  in  8  received byte.
- `rx_pop_i`  in  1  one-cycle strobe; `rx_data_i` valid.
- `tx_data_o`  out  8  next byte to shift out.
- `tx_ack_o`  out  1  one-cycle strobe; transceiver loads `tx_data_o`.
- `csr_addr_o`  out  ADDR_WIDTH  CSR address.
- `csr_we_o`  out  1  one-cycle write strobe.
- `csr_wdata_o`  out  DATA_WIDTH  write data.
- `csr_re_o`  out  1  one-cycle read strobe.
- `csr_rdata_i`  in  DATA_WIDTH  read data.
- `active_o`  out  1  high whenever state != IDLE.

## Operation
- Frame: command byte, then ADDR_BYTES address bytes (MSB first), then data bytes.
- Command byte: bit7 selects W (1) or R (0). bit6 is FIX: hold the address for the whole burst. bits[5:0] are ignored.
- The address is the concatenation of the address bytes, truncated to the low ADDR_WIDTH bits.
- States: IDLE, ADDR, WDATA, RWAIT, RDATA.
- IDLE, on pop: latch W and FIX. Go to ADDR.
- ADDR, on each pop: shift the byte into the address register. After the ADDR_BYTES-th byte, go to WDATA if W, otherwise issue a read and go to RWAIT.
- WDATA, on each pop: shift the byte into the write word, MSB first, and count bytes.
  - On the DATA_BYTES-th byte, pulse `csr_we_o` with the assembled word and the current address.
  - The next cycle, the address increments unless FIX is set. The byte count clears.
  - Unbounded bursts are allowed.
- Read issue: pulse `csr_re_o` at the current address. Sample `csr_rdata_i` RD_LATENCY cycles later into the tx shift register. Present the MSB byte with `tx_ack_o`, then go to RDATA.
- RDATA, on each pop:
  - If bytes of the word remain, present the next byte with `tx_ack_o`.
  - If the word is exhausted, increment the address unless FIX is set, issue a new read and go to RWAIT.
  - Received bytes in RDATA are don't-care.
- Pops in RWAIT are dropped. This is a protocol violation; the bridge does not raise an error.
- Address arithmetic is modulo 2^ADDR_WIDTH, so 0x...FF..F wraps to 0.
- `spi_rst_i`: return to IDLE and clear the address, byte count and partial words. No `csr_we_o` is issued for a partial word. A pending read's data is discarded and `tx_ack_o` is suppressed.
- Priority: `rst` low, then `spi_rst_i`, then `rx_pop_i`.

## Timing
- Reset (`rst`=0 at a clk edge): every output is 0 on the next cycle and the state is IDLE.
- Write: `csr_we_o` asserts 1 cycle after the pop of the last byte of a word. The incremented `csr_addr_o` is visible 2 cycles after that pop.
- Read issue: `csr_re_o` asserts 1 cycle after the triggering pop (last address byte, or last byte of a word).
- Read data: `csr_rdata_i` is sampled RD_LATENCY cycles after `csr_re_o` rises. With RD_LATENCY=0 it is sampled in the same cycle. `tx_ack_o` follows one cycle after sampling.
- First byte of a word: `tx_ack_o` asserts RD_LATENCY+2 cycles after the pop.
- Later bytes of a word: `tx_ack_o` asserts 1 cycle after the pop.
- `tx_data_o` holds its value until the next `tx_ack_o`.
- Requirement: the pop spacing is at least RD_LATENCY+3 clk cycles. This is always satisfied at byte-rate SPI.
- `csr_we_o` and `csr_re_o` are never asserted together. Each is a single-cycle pulse.

## Test plan
- Write, defaults. Bytes 80,01,23,AA,BB -> `csr_we_o` at addr 0x123 with data AA, then at 0x124 with data BB.
- Read with increment, RD_LATENCY=1. Bytes 00,08,00; rdata 5A -> `csr_re_o` at 0x800; `tx_ack_o` with 5A 3 cycles after the pop. The next dummy pop -> `csr_re_o` at 0x801.
- FIX write. Bytes C0,00,40,11,22,33 -> three `csr_we_o` pulses, all at addr 0x040, with data 11, 22, 33.
- DATA_BYTES=2.
  - Write 80,00,10,12,34 -> a single `csr_we_o` with data 1234 at 0x010.
  - Read of rdata BEEF -> tx bytes BE then EF, with exactly one `csr_re_o` per 2 bytes.
- Wrap, ADDR_WIDTH=12. Write burst starting at 0xFFF, two bytes -> the second `csr_we_o` is at 0x000.
- Aborts.
  - DATA_BYTES=2: `spi_rst_i` after 1 data byte -> no `csr_we_o`. A following transaction decodes correctly.
  - `rst`=0 during RWAIT -> all outputs 0 next cycle and no `tx_ack_o`.

Source files
------------

// File: rtl/csr_spi_bridge_if.sv
// csr_spi_bridge_if: spi byte stream and csr bus bundle for csr_spi_bridge
interface csr_spi_bridge_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_BYTES = 1
);
  localparam int DATA_WIDTH = 8 * DATA_BYTES;
  logic                  spi_rst_i;
  logic [7:0]            rx_data_i;
  logic                  rx_pop_i;
  logic [7:0]            tx_data_o;
  logic                  tx_ack_o;
  logic [ADDR_WIDTH-1:0] csr_addr_o;
  logic                  csr_we_o;
  logic [DATA_WIDTH-1:0] csr_wdata_o;
  logic                  csr_re_o;
  logic [DATA_WIDTH-1:0] csr_rdata_i;
  logic                  active_o;
  modport master (
    input  spi_rst_i, rx_data_i, rx_pop_i, csr_rdata_i,
    output tx_data_o, tx_ack_o, csr_addr_o, csr_we_o, csr_wdata_o, csr_re_o, active_o
  );
  modport slave (
    output spi_rst_i, rx_data_i, rx_pop_i, csr_rdata_i,
    input  tx_data_o, tx_ack_o, csr_addr_o, csr_we_o, csr_wdata_o, csr_re_o, active_o
  );
endinterface

// File: rtl/csr_spi_bridge.sv
// csr_spi_bridge: spi byte stream to csr bus bridge with bursts, multi-byte words and read latency
module csr_spi_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_BYTES = 1,
  parameter int RD_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  csr_spi_bridge_if.master bus
);
  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int DW = 8 * DATA_BYTES;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDATA} state_t;
  state_t state_q, state_d;
  logic w_q, w_d, fix_q, fix_d, we_q, we_d, re_q, re_d, ack_q, ack_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, tx_q, tx_d;
  logic addr_last, word_last, word_done, lat_done;
  assign addr_last = cnt_q == 3'(ADDR_BYTES - 1);
  assign word_last = cnt_q == 3'(DATA_BYTES - 1);
  assign word_done = cnt_q == 3'(DATA_BYTES);
  assign lat_done  = lat_q == 2'(RD_LATENCY);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      w_q     <= 1'b0;
      fix_q   <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      lat_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      fix_q   <= fix_d;
      we_q    <= we_d;
      re_q    <= re_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tx_q    <= tx_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (bus.spi_rst_i) state_d = IDLE;
    else if (state_q == RWAIT) state_d = lat_done ? RDATA : RWAIT;
    else if (bus.rx_pop_i)
      case (state_q)
        IDLE:    state_d = ADDR;
        ADDR:    state_d = addr_last ? (w_q ? WDATA : RWAIT) : ADDR;
        RDATA:   state_d = word_done ? RWAIT : RDATA;
        default: state_d = state_q;
      endcase
  end
  always_comb begin
    w_d     = w_q;
    fix_d   = fix_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    addr_d  = (we_q && !fix_q) ? addr_q + 1'b1 : addr_q;
    wdata_d = wdata_q;
    tx_d    = tx_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    ack_d   = 1'b0;
    if (bus.spi_rst_i) begin
      addr_d  = '0;
      cnt_d   = '0;
      lat_d   = '0;
      wdata_d = '0;
    end else if (state_q == RWAIT) begin
      lat_d = lat_q + 1'b1;
      tx_d  = lat_done ? bus.csr_rdata_i : tx_q;
      ack_d = lat_done;
      cnt_d = lat_done ? 3'd1 : cnt_q;
    end else if (bus.rx_pop_i) begin
      case (state_q)
        IDLE: begin
          w_d   = bus.rx_data_i[7];
          fix_d = bus.rx_data_i[6];
          cnt_d = '0;
        end
        ADDR: begin
          addr_d = (addr_q << 8) | ADDR_WIDTH'(bus.rx_data_i);
          cnt_d  = addr_last ? 3'd0 : cnt_q + 3'd1;
          re_d   = addr_last && !w_q;
          lat_d  = '0;
        end
        WDATA: begin
          wdata_d = (wdata_q << 8) | DW'(bus.rx_data_i);
          cnt_d   = word_last ? 3'd0 : cnt_q + 3'd1;
          we_d    = word_last;
        end
        RDATA: begin
          re_d   = word_done;
          ack_d  = !word_done;
          lat_d  = '0;
          cnt_d  = word_done ? 3'd0 : cnt_q + 3'd1;
          tx_d   = word_done ? tx_q : tx_q << 8;
          addr_d = (word_done && !fix_q) ? addr_q + 1'b1 : addr_q;
        end
        default: ;
      endcase
    end
  end
  always_comb begin
    bus.tx_data_o   = tx_q[DW-1 -: 8];
    bus.tx_ack_o    = ack_q;
    bus.csr_addr_o  = addr_q;
    bus.csr_we_o    = we_q;
    bus.csr_wdata_o = wdata_q;
    bus.csr_re_o    = re_q;
    bus.active_o    = state_q != IDLE;
  end
endmodule

// File: tb/tb_csr_spi_bridge.sv
// tb_csr_spi_bridge: two bridge configurations checked against a frame-level reference model
module tb_csr_spi_bridge;
  logic clk = 1'b0, rst = 1'b0, spi_rst = 1'b0, pop = 1'b0, sel = 1'b0;
  logic [7:0] rx = 8'h0;
  logic [15:0] rdata = 16'h0;
  logic [15:0] rmem [4096];
  logic [11:0] raddr = 12'h0;
  logic [15:0] amask = 16'h0fff, a_end = 16'h0;
  int cyc = 0, tests = 0, fails = 0, both = 0, since = 7, db = 1, lat = 1;
  logic [7:0] fr[$];
  int pc[$];
  logic [63:0] wq[$], rq[$], aq[$], ewq[$], erq[$], eaq[$];

  csr_spi_bridge_if #(.ADDR_WIDTH(12), .DATA_BYTES(1)) ia();
  csr_spi_bridge_if #(.ADDR_WIDTH(10), .DATA_BYTES(2)) ib();
  csr_spi_bridge #(.ADDR_WIDTH(12), .DATA_BYTES(1), .RD_LATENCY(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
  csr_spi_bridge #(.ADDR_WIDTH(10), .DATA_BYTES(2), .RD_LATENCY(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

  assign ia.spi_rst_i   = spi_rst;
  assign ia.rx_data_i   = rx;
  assign ia.rx_pop_i    = pop & ~sel;
  assign ia.csr_rdata_i = rdata[7:0];
  assign ib.spi_rst_i   = spi_rst;
  assign ib.rx_data_i   = rx;
  assign ib.rx_pop_i    = pop & sel;
  assign ib.csr_rdata_i = rdata;

  wire [7:0]  o_tx     = sel ? ib.tx_data_o : ia.tx_data_o;
  wire        o_ack    = sel ? ib.tx_ack_o : ia.tx_ack_o;
  wire [11:0] o_addr   = sel ? {2'b00, ib.csr_addr_o} : ia.csr_addr_o;
  wire        o_we     = sel ? ib.csr_we_o : ia.csr_we_o;
  wire [15:0] o_wdata  = sel ? ib.csr_wdata_o : {8'h00, ia.csr_wdata_o};
  wire        o_re     = sel ? ib.csr_re_o : ia.csr_re_o;
  wire        o_active = sel ? ib.active_o : ia.active_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_we) wq.push_back({32'(cyc), 4'h0, o_addr, o_wdata});
    if (o_re) rq.push_back({32'(cyc), 4'h0, o_addr, 16'h0});
    if (o_ack) aq.push_back({32'(cyc), 24'h0, o_tx});
    if (o_we && o_re) both++;
  end

  // memory answers only in the exact cycle the bridge should sample; otherwise it shows inverted data
  always @(negedge clk) begin
    if (o_re) begin
      since = 0;
      raddr = o_addr;
    end else if (since < 7) since++;
    rdata = (since == lat) ? rmem[raddr] : ~rmem[raddr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic use_dut(input logic s);
    sel   = s;
    db    = s ? 2 : 1;
    lat   = s ? 0 : 1;
    amask = s ? 16'h03ff : 16'h0fff;
  endtask

  function automatic logic [7:0] rbyte(input logic [11:0] a, input int k);
    logic [15:0] w;
    w = rmem[a];
    return (db == 2 && k == 0) ? w[15:8] : w[7:0];
  endfunction

  task automatic pop_byte(input logic [7:0] b);
    @(negedge clk);
    rx  = b;
    pop = 1'b1;
    pc.push_back(cyc);
    @(negedge clk);
    pop = 1'b0;
    rx  = 8'($urandom);
    repeat (4 + $urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic end_session(input string tag);
    @(negedge clk);
    spi_rst = 1'b1;
    @(negedge clk);
    spi_rst = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 64'(o_active), 64'(0));
    check({tag, "_addr_clr"}, 64'(o_addr), 64'(0));
  endtask

  task automatic model();
    logic [15:0] a, word;
    logic fx;
    ewq.delete();
    erq.delete();
    eaq.delete();
    fx   = fr[0][6];
    a    = {fr[1], fr[2]} & amask;
    word = 16'h0;
    if (fr[0][7]) begin
      for (int i = 3; i < fr.size(); i++) begin
        word = (word << 8) | 16'(fr[i]);
        if ((i - 3) % db == db - 1) begin
          ewq.push_back({32'(pc[i] + 1), 4'h0, a[11:0], word});
          word = 16'h0;
          if (!fx) a = (a + 16'd1) & amask;
        end
      end
    end else begin
      erq.push_back({32'(pc[2] + 1), 4'h0, a[11:0], 16'h0});
      eaq.push_back({32'(pc[2] + lat + 2), 24'h0, rbyte(a[11:0], 0)});
      for (int i = 3; i < fr.size(); i++) begin
        int j = (i - 3) % db;
        if (j == db - 1) begin
          if (!fx) a = (a + 16'd1) & amask;
          erq.push_back({32'(pc[i] + 1), 4'h0, a[11:0], 16'h0});
          eaq.push_back({32'(pc[i] + lat + 2), 24'h0, rbyte(a[11:0], 0)});
        end else eaq.push_back({32'(pc[i] + 1), 24'h0, rbyte(a[11:0], j + 1)});
      end
    end
    a_end = a;
  endtask

  task automatic run_frame(input string tag);
    pc.delete();
    wq.delete();
    rq.delete();
    aq.delete();
    foreach (fr[i]) pop_byte(fr[i]);
    repeat (6) @(negedge clk);
    model();
    check({tag, "_active"}, 64'(o_active), 64'(1));
    check({tag, "_n_we"}, 64'(wq.size()), 64'(ewq.size()));
    for (int i = 0; i < wq.size() && i < ewq.size(); i++) check({tag, "_we"}, wq[i], ewq[i]);
    check({tag, "_n_re"}, 64'(rq.size()), 64'(erq.size()));
    for (int i = 0; i < rq.size() && i < erq.size(); i++) check({tag, "_re"}, rq[i], erq[i]);
    check({tag, "_n_ack"}, 64'(aq.size()), 64'(eaq.size()));
    for (int i = 0; i < aq.size() && i < eaq.size(); i++) check({tag, "_ack"}, aq[i], eaq[i]);
    check({tag, "_addr_end"}, 64'(o_addr), 64'(a_end[11:0]));
    if (eaq.size() > 0) check({tag, "_tx_hold"}, 64'(o_tx), 64'(eaq[eaq.size() - 1][7:0]));
    end_session(tag);
  endtask

  task automatic rand_frame();
    int n;
    n = $urandom_range(1, 5);
    fr.delete();
    fr.push_back({1'($urandom), 1'($urandom), 6'($urandom)});
    fr.push_back(8'($urandom));
    fr.push_back(8'($urandom));
    repeat (n) fr.push_back(8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"}, 64'(o_tx), 64'(0));
    check({tag, "_ack"}, 64'(o_ack), 64'(0));
    check({tag, "_addr"}, 64'(o_addr), 64'(0));
    check({tag, "_we"}, 64'(o_we), 64'(0));
    check({tag, "_wdata"}, 64'(o_wdata), 64'(0));
    check({tag, "_re"}, 64'(o_re), 64'(0));
    check({tag, "_active"}, 64'(o_active), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rmem[i] = 16'($urandom);
    rmem[12'h800] = 16'h005a;
    rmem[12'h020] = 16'hbeef;
    use_dut(1'b0);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_a");
    use_dut(1'b1);
    check_reset_outputs("rst_b");
    use_dut(1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    fr = {8'h80, 8'h01, 8'h23, 8'haa, 8'hbb};
    run_frame("wr_def");
    fr = {8'h00, 8'h08, 8'h00, 8'hff};
    run_frame("rd_inc");
    fr = {8'hc0, 8'h00, 8'h40, 8'h11, 8'h22, 8'h33};
    run_frame("wr_fix");
    fr = {8'h80, 8'h0f, 8'hff, 8'h01, 8'h02};
    run_frame("wr_wrap");
    fr = {8'h40, 8'h01, 8'h00, 8'h00, 8'h00};
    run_frame("rd_fix");
    fr = {8'h80, 8'hf1, 8'h23, 8'h44};
    run_frame("wr_trunc_a");
    for (int k = 0; k < 6; k++) begin
      rand_frame();
      run_frame("rand_a");
    end

    use_dut(1'b1);
    fr = {8'h80, 8'h00, 8'h10, 8'h12, 8'h34};
    run_frame("wr_w16");
    fr = {8'h00, 8'h00, 8'h20, 8'hff, 8'hff, 8'hff};
    run_frame("rd_w16");
    fr = {8'h80, 8'hff, 8'hff, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame("wr_wrap_b");
    pc.delete();
    wq.delete();
    pop_byte(8'h80);
    pop_byte(8'h00);
    pop_byte(8'h10);
    pop_byte(8'h12);
    end_session("abort_wr");
    repeat (4) @(negedge clk);
    check("abort_wr_no_we", 64'(wq.size()), 64'(0));
    fr = {8'h80, 8'h00, 8'h30, 8'h56, 8'h78};
    run_frame("after_abort");
    for (int k = 0; k < 6; k++) begin
      rand_frame();
      run_frame("rand_b");
    end

    use_dut(1'b0);
    pc.delete();
    rq.delete();
    aq.delete();
    pop_byte(8'h00);
    pop_byte(8'h08);
    @(negedge clk);
    rx  = 8'h00;
    pop = 1'b1;
    @(negedge clk);
    pop     = 1'b0;
    spi_rst = 1'b1;
    @(negedge clk);
    spi_rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_rd_n_re", 64'(rq.size()), 64'(1));
    check("abort_rd_no_ack", 64'(aq.size()), 64'(0));
    check("abort_rd_idle", 64'(o_active), 64'(0));

    aq.delete();
    pop_byte(8'h00);
    pop_byte(8'h08);
    @(negedge clk);
    rx  = 8'h00;
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_rwait");
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_rwait_no_ack", 64'(aq.size()), 64'(0));

    check("we_re_exclusive", 64'(both), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
